// File: rtl/lut_config_loader_if.sv
// Stream handshake bundle for the LUT configuration loader.
// The master drives beats (bs_valid/bs_data), the slave answers with bs_ready.
interface lut_config_loader_if #(
    parameter int CONFIG_WIDTH = 1
) ();
    logic                    bs_valid;
    logic                    bs_ready;
    logic [CONFIG_WIDTH-1:0] bs_data;

    modport master (
        output bs_valid,
        output bs_data,
        input  bs_ready
    );

    modport slave (
        input  bs_valid,
        input  bs_data,
        output bs_ready
    );
endinterface

// File: rtl/lut_config_loader.sv
// lut_config_loader: writer side of the LUT block-configuration port.
// Collects MEM_SIZE/CONFIG_WIDTH stream beats (beat 0 ends up in the lowest
// bits), commits the word to config_out and pulses cen/done for one cycle.
// Optional build macro: LUT_CONFIG_LOADER_PARITY_EN adds a CHECK state that
// takes one extra beat carrying the even parity of the word; a mismatch sets
// the sticky cfg_err and drops the word without a strobe.
module lut_config_loader #(
    parameter int INPUTS       = 4,
    parameter int MEM_SIZE     = 2**INPUTS,
    parameter int CONFIG_WIDTH = 1
) (
    input  logic                  cclk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    lut_config_loader_if.slave    bs,
    output logic [MEM_SIZE-1:0]   config_out,
    output logic                  cen,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam int                N_BEATS   = MEM_SIZE / CONFIG_WIDTH;
    localparam int                CNT_W     = $clog2(N_BEATS) + 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(N_BEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

`ifdef LUT_CONFIG_LOADER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd3
    } state_e;
`endif

    state_e                          state_r;
    logic [CNT_W-1:0]                beat_cnt_r;
    logic [MEM_SIZE-1:0]             shift_r;
    logic [MEM_SIZE-1:0]             config_out_r;
    logic                            cen_r;
    logic                            done_r;
    logic                            busy_r;
    logic                            bs_ready_r;
    logic                            beat_fire_s;
    logic [MEM_SIZE+CONFIG_WIDTH-1:0] shift_cat_s;
    logic [MEM_SIZE-1:0]             word_next_s;

`ifdef LUT_CONFIG_LOADER_PARITY_EN
    logic                            cfg_err_r;

    // Even parity over the whole configuration word
    function automatic logic even_parity(input logic [MEM_SIZE-1:0] word);
        even_parity = ^word;
    endfunction
`endif

    // Beat acceptance and the shift-register image after inserting the beat at the top
    always_comb begin
        beat_fire_s = bs.bs_valid & bs_ready_r;
        shift_cat_s = {bs.bs_data, shift_r};
        word_next_s = shift_cat_s[MEM_SIZE+CONFIG_WIDTH-1:CONFIG_WIDTH];
    end

    // Load sequencer: state, beat counter, shift register and every registered output
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            beat_cnt_r   <= {CNT_W{1'b0}};
            shift_r      <= {MEM_SIZE{1'b0}};
            config_out_r <= {MEM_SIZE{1'b0}};
            cen_r        <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            bs_ready_r   <= 1'b0;
`ifdef LUT_CONFIG_LOADER_PARITY_EN
            cfg_err_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cen_r  <= 1'b0;
                    done_r <= 1'b0;
                    if (start) begin
                        state_r    <= ST_SHIFT;
                        beat_cnt_r <= {CNT_W{1'b0}};
                        shift_r    <= {MEM_SIZE{1'b0}};
                        busy_r     <= 1'b1;
                        bs_ready_r <= 1'b1;
`ifdef LUT_CONFIG_LOADER_PARITY_EN
                        cfg_err_r  <= 1'b0;
`endif
                    end else begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        bs_ready_r <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    // abort outranks a beat presented on the same edge
                    if (abort) begin
                        state_r    <= ST_IDLE;
                        beat_cnt_r <= {CNT_W{1'b0}};
                        shift_r    <= {MEM_SIZE{1'b0}};
                        busy_r     <= 1'b0;
                        bs_ready_r <= 1'b0;
                    end else if (beat_fire_s) begin
                        if (beat_cnt_r == LAST_BEAT) begin
                            beat_cnt_r <= {CNT_W{1'b0}};
`ifdef LUT_CONFIG_LOADER_PARITY_EN
                            // word parks in the shift register until the parity beat arrives
                            shift_r    <= word_next_s;
                            state_r    <= ST_CHECK;
`else
                            shift_r      <= {MEM_SIZE{1'b0}};
                            config_out_r <= word_next_s;
                            state_r      <= ST_COMMIT;
                            cen_r        <= 1'b1;
                            done_r       <= 1'b1;
                            bs_ready_r   <= 1'b0;
`endif
                        end else begin
                            shift_r    <= word_next_s;
                            beat_cnt_r <= beat_cnt_r + CNT_ONE;
                        end
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end

`ifdef LUT_CONFIG_LOADER_PARITY_EN
                ST_CHECK: begin
                    if (abort) begin
                        state_r    <= ST_IDLE;
                        shift_r    <= {MEM_SIZE{1'b0}};
                        busy_r     <= 1'b0;
                        bs_ready_r <= 1'b0;
                    end else if (beat_fire_s) begin
                        shift_r    <= {MEM_SIZE{1'b0}};
                        bs_ready_r <= 1'b0;
                        if (bs.bs_data[0] == even_parity(shift_r)) begin
                            config_out_r <= shift_r;
                            state_r      <= ST_COMMIT;
                            cen_r        <= 1'b1;
                            done_r       <= 1'b1;
                        end else begin
                            cfg_err_r <= 1'b1;
                            state_r   <= ST_IDLE;
                            busy_r    <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_CHECK;
                    end
                end
`endif

                ST_COMMIT: begin
                    // strobe lasts exactly one cycle; abort/start are not looked at here
                    state_r    <= ST_IDLE;
                    cen_r      <= 1'b0;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    bs_ready_r <= 1'b0;
                end

                default: begin
                    state_r    <= ST_IDLE;
                    beat_cnt_r <= {CNT_W{1'b0}};
                    shift_r    <= {MEM_SIZE{1'b0}};
                    cen_r      <= 1'b0;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    bs_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bs.bs_ready = bs_ready_r;
    assign config_out  = config_out_r;
    assign cen         = cen_r;
    assign done        = done_r;
    assign busy        = busy_r;
`ifdef LUT_CONFIG_LOADER_PARITY_EN
    assign cfg_err     = cfg_err_r;
`else
    assign cfg_err     = 1'b0;
`endif

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader. Two instances: a 4-bit word with
// 1-bit beats and a 16-bit word with 2-bit beats. Honours the optional
// LUT_CONFIG_LOADER_PARITY_EN build by appending the parity beat.
module tb_lut_config_loader;

    logic cclk = 1'b0;
    always #5 cclk = ~cclk;

    logic        rst_n;
    logic        start_a, abort_a, start_b, abort_b;
    logic [3:0]  config_out_a;
    logic [15:0] config_out_b;
    logic        cen_a, busy_a, done_a, cfg_err_a;
    logic        cen_b, busy_b, done_b, cfg_err_b;

    lut_config_loader_if #(.CONFIG_WIDTH(1)) ifa ();
    lut_config_loader_if #(.CONFIG_WIDTH(2)) ifb ();

    lut_config_loader #(.INPUTS(2), .MEM_SIZE(4), .CONFIG_WIDTH(1)) dut_a (
        .cclk(cclk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .bs(ifa),
        .config_out(config_out_a), .cen(cen_a), .busy(busy_a), .done(done_a),
        .cfg_err(cfg_err_a)
    );

    lut_config_loader #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(2)) dut_b (
        .cclk(cclk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .bs(ifb),
        .config_out(config_out_b), .cen(cen_b), .busy(busy_b), .done(done_b),
        .cfg_err(cfg_err_b)
    );

    int   total = 0;
    int   bad   = 0;
    int   cen_cnt_a = 0;
    int   cen_cnt_b = 0;
    int   dbl_cnt   = 0;
    logic cen_a_q = 1'b0;
    logic cen_b_q = 1'b0;

    // Count strobes per instance and catch any strobe lasting two cycles
    always @(posedge cclk) begin
        cen_a_q <= cen_a;
        cen_b_q <= cen_b;
        if (cen_a) cen_cnt_a <= cen_cnt_a + 1;
        if (cen_b) cen_cnt_b <= cen_cnt_b + 1;
        if ((cen_a && cen_a_q) || (cen_b && cen_b_q)) dbl_cnt <= dbl_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    // Load dut_a; order[3] is the first beat sent, gaps[i] inserts an idle cycle before beat i
    task automatic load_a(input logic [3:0] order, input logic [3:0] gaps,
                          input logic [3:0] exp, input string tag);
        int c0;
        c0 = cen_cnt_a;
        check({tag, "_idle"}, 32'(busy_a), 32'd0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check({tag, "_busy"}, 32'(busy_a), 32'd1);
        check({tag, "_ready"}, 32'(ifa.bs_ready), 32'd1);
        check({tag, "_err0"}, 32'(cfg_err_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (gaps[i]) begin
                ifa.bs_valid = 1'b0;
                ifa.bs_data  = ~order[3-i];
                tick();
            end
            ifa.bs_valid = 1'b1;
            ifa.bs_data  = order[3-i];
            tick();
        end
`ifdef LUT_CONFIG_LOADER_PARITY_EN
        ifa.bs_valid = 1'b1;
        ifa.bs_data  = ^exp;
        tick();
`endif
        ifa.bs_valid = 1'b0;
        check({tag, "_cen"}, 32'(cen_a), 32'd1);
        check({tag, "_done"}, 32'(done_a), 32'd1);
        check({tag, "_word"}, 32'(config_out_a), 32'(exp));
        check({tag, "_ready_commit"}, 32'(ifa.bs_ready), 32'd0);
        tick();
        check({tag, "_cen_off"}, 32'(cen_a), 32'd0);
        check({tag, "_busy_off"}, 32'(busy_a), 32'd0);
        check({tag, "_one_cen"}, 32'(cen_cnt_a - c0), 32'd1);
    endtask

    // Load dut_b with eight 2-bit beats, random valid gaps between beats
    task automatic load_b(input logic [1:0] beats [8], input logic [15:0] exp, input string tag);
        int c0;
        c0 = cen_cnt_b;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) begin
                ifb.bs_valid = 1'b0;
                ifb.bs_data  = 2'b10;
                tick();
            end
            ifb.bs_valid = 1'b1;
            ifb.bs_data  = beats[i];
            tick();
        end
`ifdef LUT_CONFIG_LOADER_PARITY_EN
        ifb.bs_valid = 1'b1;
        ifb.bs_data  = {1'b0, ^exp};
        tick();
`endif
        ifb.bs_valid = 1'b0;
        check({tag, "_cen"}, 32'(cen_b), 32'd1);
        check({tag, "_word"}, 32'(config_out_b), 32'(exp));
        tick();
        check({tag, "_cen_off"}, 32'(cen_b), 32'd0);
        check({tag, "_busy_off"}, 32'(busy_b), 32'd0);
        check({tag, "_one_cen"}, 32'(cen_cnt_b - c0), 32'd1);
    endtask

    typedef struct {
        string      name;
        logic [3:0] order;
        logic [3:0] gaps;
        logic [3:0] exp;
    } vec_t;

    vec_t       vecs [7];
    logic [1:0] seq_b [8];
    int         c0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // beat 0 lands in bit 0: order 1011 sends 1,0,1,1 -> 4'b1101
        vecs[0] = '{"basic", 4'b1011, 4'b0000, 4'b1101};
        vecs[1] = '{"low",   4'b1000, 4'b0101, 4'b0001};
        vecs[2] = '{"high",  4'b0001, 4'b1000, 4'b1000};
        vecs[3] = '{"ones",  4'b1111, 4'b0010, 4'b1111};
        vecs[4] = '{"zero",  4'b0000, 4'b1111, 4'b0000};
        vecs[5] = '{"pair",  4'b1100, 4'b0110, 4'b0011};
        vecs[6] = '{"mid",   4'b0110, 4'b0001, 4'b0110};

        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        ifa.bs_valid = 1'b0; ifa.bs_data = 1'b0;
        ifb.bs_valid = 1'b0; ifb.bs_data = 2'b00;

        // reset held while inputs wiggle
        for (int i = 0; i < 4; i++) begin
            start_a = 1'($urandom); abort_a = 1'($urandom);
            start_b = 1'($urandom); abort_b = 1'($urandom);
            ifa.bs_valid = 1'($urandom); ifa.bs_data = 1'($urandom);
            ifb.bs_valid = 1'($urandom); ifb.bs_data = 2'($urandom);
            tick();
        end
        check("rst_outs_a", 32'({config_out_a, cen_a, busy_a, done_a, cfg_err_a, ifa.bs_ready}), 32'd0);
        check("rst_outs_b", 32'({config_out_b, cen_b, busy_b, done_b, cfg_err_b, ifb.bs_ready}), 32'd0);
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        ifa.bs_valid = 1'b0; ifb.bs_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'({busy_a, busy_b}), 32'd0);
        check("post_rst_ready", 32'({ifa.bs_ready, ifb.bs_ready}), 32'd0);

        // table-driven loads on the 4-bit instance
        for (int i = 0; i < 7; i++) begin
            load_a(vecs[i].order, vecs[i].gaps, vecs[i].exp, vecs[i].name);
        end

        // start held high through a load is ignored; late valid is not accepted
        c0 = cen_cnt_a;
        start_a = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ifa.bs_valid = 1'b1;
            ifa.bs_data  = (i == 1) ? 1'b1 : 1'b0;
            tick();
        end
        start_a = 1'b0;
        check("ovl_cen", 32'(cen_a), 32'd1);
        check("ovl_word", 32'(config_out_a), 32'h2);
        check("ovl_ready_commit", 32'(ifa.bs_ready), 32'd0);
        tick();
        check("ovl_ready_idle", 32'(ifa.bs_ready), 32'd0);
        check("ovl_busy_idle", 32'(busy_a), 32'd0);
        tick();
        ifa.bs_valid = 1'b0;
        check("ovl_word_hold", 32'(config_out_a), 32'h2);
        check("ovl_one_cen", 32'(cen_cnt_a - c0), 32'd1);

        // abort after two beats; the beat coinciding with abort is dropped
        seq_b = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
        load_b(seq_b, 16'hFFFF, "ffff");
        c0 = cen_cnt_b;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        ifb.bs_valid = 1'b1; ifb.bs_data = 2'b01; tick();
        ifb.bs_valid = 1'b1; ifb.bs_data = 2'b10; tick();
        abort_b = 1'b1; ifb.bs_data = 2'b00;
        tick();
        abort_b = 1'b0; ifb.bs_valid = 1'b0;
        check("abort_busy", 32'(busy_b), 32'd0);
        check("abort_ready", 32'(ifb.bs_ready), 32'd0);
        tick();
        tick();
        check("abort_word", 32'(config_out_b), 32'hFFFF);
        check("abort_no_cen", 32'(cen_cnt_b - c0), 32'd0);

        // wide beats with stalls: beat 0 at [1:0] -> each byte 8'b00_11_10_01
        seq_b = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        load_b(seq_b, 16'h3939, "stall_a");
        seq_b = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00};
        load_b(seq_b, 16'h1B1B, "stall_b");

        // start and abort together in IDLE: start wins; abort in SHIFT then empties
        start_b = 1'b1; abort_b = 1'b1;
        tick();
        start_b = 1'b0; abort_b = 1'b0;
        check("start_wins", 32'(busy_b), 32'd1);
        abort_b = 1'b1;
        tick();
        abort_b = 1'b0;
        check("abort_idle_busy", 32'(busy_b), 32'd0);
        check("abort_idle_word", 32'(config_out_b), 32'h1B1B);

`ifdef LUT_CONFIG_LOADER_PARITY_EN
        // data 1,0,1,1 with wrong parity 0: error, no strobe, word unchanged
        c0 = cen_cnt_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifa.bs_valid = 1'b1;
            ifa.bs_data  = (i == 1) ? 1'b0 : 1'b1;
            tick();
        end
        check("par_check_ready", 32'(ifa.bs_ready), 32'd1);
        ifa.bs_valid = 1'b1; ifa.bs_data = 1'b0;
        tick();
        ifa.bs_valid = 1'b0;
        check("par_err", 32'(cfg_err_a), 32'd1);
        check("par_err_cen", 32'(cen_a), 32'd0);
        check("par_err_busy", 32'(busy_a), 32'd0);
        tick();
        check("par_err_sticky", 32'(cfg_err_a), 32'd1);
        check("par_err_word", 32'(config_out_a), 32'h2);
        check("par_err_no_cen", 32'(cen_cnt_a - c0), 32'd0);
        load_a(4'b1011, 4'b0000, 4'b1101, "par_ok");
`endif

        // reset after three of four beats: word cleared, no strobe
        c0 = cen_cnt_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifa.bs_valid = 1'b1; ifa.bs_data = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("midrst_word", 32'(config_out_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        ifa.bs_valid = 1'b0;
        check("midrst_no_cen", 32'(cen_cnt_a - c0), 32'd0);
        check("midrst_word_hold", 32'(config_out_a), 32'd0);
        check("no_double_cen", 32'(dbl_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
